// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button front end and run control for the stopwatch datapath.
// Both raw buttons are synchronised and debounced. Rising debounced edges drive
// an IDLE/RUN/PAUSE machine. A prescaler turns clk into a one-cycle enable pulse
// for the downstream time counter.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | stopped and cleared; prescaler forced to 0
// ST_RUN   | counting; prescaler advances and emits enable on wrap
// ST_PAUSE | stopped; prescaler phase held so a resume continues in phase
module stopwatch_ctrl #(
    parameter int DIV       = 1000,
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_start,
    input  logic btn_clear,
    output logic enable,
    output logic running,
    output logic clr
);

    localparam int CNT_W = $clog2(DIV);
    localparam int DB_W  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);

    localparam int BTN_START = 0;
    localparam int BTN_CLEAR = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    logic [1:0]           btn_raw;
    logic [1:0]           sync1_q;
    logic [1:0]           sync2_q;
    logic [1:0]           level_q;
    logic [1:0]           level_d;
    logic [1:0][DB_W-1:0] db_cnt_q;
    logic [1:0][DB_W-1:0] db_cnt_d;
    logic [1:0]           press;
    logic                 start_ev;
    logic                 clear_ev;

    state_t               state_q;
    logic [CNT_W-1:0]     div_cnt_q;
    logic                 enable_q;
    logic                 running_q;
    logic                 clr_q;

    assign btn_raw = {btn_clear, btn_start};

    // Two-flop synchroniser per button; nothing downstream sees btn_raw directly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: the level flips only after DB_CYCLES consecutive differing samples.
    // A rising flip is the press event and is consumed by the FSM on the same edge.
    always_comb begin
        level_d  = level_q;
        db_cnt_d = '0;
        press    = '0;
        for (int b = 0; b < 2; b++) begin
            if (sync2_q[b] != level_q[b]) begin
                if (db_cnt_q[b] == DB_LAST) begin
                    level_d[b] = ~level_q[b];
                    press[b]   = ~level_q[b];
                end else begin
                    db_cnt_d[b] = db_cnt_q[b] + DB_W'(1);
                end
            end
        end
    end

    // Debounced levels and their run-length counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_q  <= '0;
            db_cnt_q <= '0;
        end else begin
            level_q  <= level_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    assign start_ev = press[BTN_START];
    assign clear_ev = press[BTN_CLEAR];

    // Run-control FSM with prescaler; all outputs registered alongside the state.
    // The prescaler only advances on edges that stay in RUN, so a pause taken on
    // the wrap edge keeps DIV-1 and suppresses that pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            div_cnt_q <= '0;
            enable_q  <= 1'b0;
            running_q <= 1'b0;
            clr_q     <= 1'b0;
        end else begin
            enable_q <= 1'b0;
            clr_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    div_cnt_q <= '0;
                    if (start_ev) begin
                        state_q   <= ST_RUN;
                        running_q <= 1'b1;
                    end else begin
                        running_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (start_ev) begin
                        state_q   <= ST_PAUSE;
                        running_q <= 1'b0;
                    end else begin
                        running_q <= 1'b1;
                        if (div_cnt_q == DIV_LAST) begin
                            div_cnt_q <= '0;
                            enable_q  <= 1'b1;
                        end else begin
                            div_cnt_q <= div_cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_PAUSE: begin
                    // start has priority; a simultaneous clear is dropped
                    if (start_ev) begin
                        state_q   <= ST_RUN;
                        running_q <= 1'b1;
                    end else if (clear_ev) begin
                        state_q   <= ST_IDLE;
                        div_cnt_q <= '0;
                        clr_q     <= 1'b1;
                        running_q <= 1'b0;
                    end else begin
                        running_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    div_cnt_q <= '0;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign enable  = enable_q;
    assign running = running_q;
    assign clr     = clr_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with DIV=4, DB_CYCLES=3: a constant-vector table for a
// clean start, hand sequences for the multi-cycle corners, then random button
// activity, with every cycle compared against a behavioural reference model.
module tb_stopwatch_ctrl;

    localparam int DIV = 4;
    localparam int DB  = 3;

    logic clk       = 1'b0;
    logic reset     = 1'b0;
    logic btn_start = 1'b0;
    logic btn_clear = 1'b0;
    logic enable;
    logic running;
    logic clr;

    int checks = 0;
    int errors = 0;

    stopwatch_ctrl #(.DIV(DIV), .DB_CYCLES(DB)) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_start(btn_start),
        .btn_clear(btn_clear),
        .enable   (enable),
        .running  (running),
        .clr      (clr)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    typedef enum int {M_IDLE, M_RUN, M_PAUSE} mode_t;

    bit    raw_s[$];
    bit    raw_c[$];
    int    m_edges;
    bit    m_level[2];
    int    m_last_flip[2];
    mode_t m_mode;
    int    m_run_edges;
    bit    m_en, m_run, m_clr;

    task automatic model_reset();
        raw_s.delete();
        raw_c.delete();
        m_edges        = 0;
        m_level[0]     = 1'b0;
        m_level[1]     = 1'b0;
        m_last_flip[0] = 0;
        m_last_flip[1] = 0;
        m_mode         = M_IDLE;
        m_run_edges    = 0;
        m_en           = 1'b0;
        m_run          = 1'b0;
        m_clr          = 1'b0;
    endtask

    // Sample the debouncer sees at edge k: the raw value from two edges earlier.
    function automatic bit seen(int b, int k);
        if (k < 3) return 1'b0;
        return (b == 0) ? raw_s[k-3] : raw_c[k-3];
    endfunction

    task automatic model_edge(input bit s, input bit c);
        bit    press[2];
        bit    flip;
        mode_t nxt;
        m_edges++;
        raw_s.push_back(s);
        raw_c.push_back(c);
        for (int b = 0; b < 2; b++) begin
            press[b] = 1'b0;
            flip = 1'b1;
            for (int j = 0; j < DB; j++) begin
                if ((m_edges - j) <= m_last_flip[b] || seen(b, m_edges - j) == m_level[b])
                    flip = 1'b0;
            end
            if (flip) begin
                press[b]       = !m_level[b];
                m_level[b]     = !m_level[b];
                m_last_flip[b] = m_edges;
            end
        end
        nxt = m_mode;
        case (m_mode)
            M_IDLE:  if (press[0]) nxt = M_RUN;
            M_RUN:   if (press[0]) nxt = M_PAUSE;
            M_PAUSE: if (press[0]) nxt = M_RUN; else if (press[1]) nxt = M_IDLE;
            default: nxt = M_IDLE;
        endcase
        m_en = 1'b0;
        if (m_mode == M_RUN && nxt == M_RUN) begin
            m_run_edges++;
            m_en = ((m_run_edges % DIV) == 0);
        end
        if (nxt == M_IDLE) m_run_edges = 0;
        m_clr  = (m_mode == M_PAUSE && nxt == M_IDLE);
        m_run  = (nxt == M_RUN);
        m_mode = nxt;
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit s, input bit c);
        btn_start = s;
        btn_clear = c;
        @(posedge clk);
        model_edge(s, c);
        #1;
        check("model_enable",  enable,  m_en);
        check("model_running", running, m_run);
        check("model_clr",     clr,     m_clr);
    endtask

    task automatic hold(input bit s, input bit c, input int n);
        for (int i = 0; i < n; i++) step(s, c);
    endtask

    typedef struct {
        bit s;
        bit c;
        bit en;
        bit run;
        bit cl;
    } vec_t;

    vec_t tbl[17];
    bit   bpat[8];

    initial begin
        int  pe;
        bit  found;
        int  len;
        bit  rs, rc;

        // clean 10-cycle start pulse: RUN at edge 5, enable after edges 9, 13, 17
        tbl[0]  = '{1, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 0, 0, 0};
        tbl[2]  = '{1, 0, 0, 0, 0};
        tbl[3]  = '{1, 0, 0, 0, 0};
        tbl[4]  = '{1, 0, 0, 1, 0};
        tbl[5]  = '{1, 0, 0, 1, 0};
        tbl[6]  = '{1, 0, 0, 1, 0};
        tbl[7]  = '{1, 0, 0, 1, 0};
        tbl[8]  = '{1, 0, 1, 1, 0};
        tbl[9]  = '{1, 0, 0, 1, 0};
        tbl[10] = '{0, 0, 0, 1, 0};
        tbl[11] = '{0, 0, 0, 1, 0};
        tbl[12] = '{0, 0, 1, 1, 0};
        tbl[13] = '{0, 0, 0, 1, 0};
        tbl[14] = '{0, 0, 0, 1, 0};
        tbl[15] = '{0, 0, 0, 1, 0};
        tbl[16] = '{0, 0, 1, 1, 0};

        bpat = '{1, 0, 1, 1, 0, 1, 1, 1};

        // reset state
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_enable",  enable,  0);
        check("rst_running", running, 0);
        check("rst_clr",     clr,     0);
        reset = 1'b1;
        hold(0, 0, 50);
        check("idle_50_running", running, 0);

        // table-driven clean start
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].s, tbl[i].c);
            check("tbl_enable",  enable,  tbl[i].en);
            check("tbl_running", running, tbl[i].run);
            check("tbl_clr",     clr,     tbl[i].cl);
        end

        // async reset between edges while RUN with enable high
        #2 reset = 1'b0;
        #1;
        check("async_rst_enable",  enable,  0);
        check("async_rst_running", running, 0);
        check("async_rst_clr",     clr,     0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();

        // bounce rejection: single press accepted at edge 10
        for (int i = 0; i < 8; i++) step(bpat[i], 0);
        step(1, 0);
        check("bounce_early", running, 0);
        step(1, 0);
        check("bounce_accept", running, 1);

        // pause with div_cnt=2, phase held, resume gives enable 2 edges later
        hold(0, 0, 6);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            step(0, 0);
            if (enable) found = 1'b1;
        end
        check("pause_sync_found", found, 1);
        hold(0, 0, 2);
        hold(1, 0, 2);
        check("pause_prior_wrap", enable, 1);
        hold(1, 0, 3);
        check("pause_entry", running, 0);
        pe = 0;
        for (int i = 0; i < 8; i++) begin
            step(i < 2, 0);
            if (enable) pe++;
        end
        check("pause_no_enable", pe, 0);
        hold(1, 0, 5);
        check("resume_run", running, 1);
        step(1, 0);
        check("resume_r1", enable, 0);
        step(1, 0);
        check("resume_r2", enable, 1);

        // clear behaviour
        hold(0, 0, 6);
        hold(0, 1, 5);
        check("clear_run_ignored", running, 1);
        check("clear_run_no_clr",  clr,     0);
        hold(0, 0, 6);
        hold(1, 0, 5);
        check("clear_pause", running, 0);
        hold(0, 0, 6);
        hold(0, 1, 5);
        check("clear_strobe",     clr,     1);
        check("clear_to_idle",    running, 0);
        step(0, 1);
        check("clear_strobe_one", clr, 0);
        hold(0, 0, 6);
        hold(1, 0, 5);
        check("restart_run", running, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, 0);
            check("restart_no_early", enable, 0);
        end
        step(1, 0);
        check("restart_first", enable, 1);

        // start and clear on the same edge in PAUSE
        hold(0, 0, 6);
        hold(1, 0, 5);
        check("simul_pause", running, 0);
        hold(0, 0, 6);
        hold(1, 1, 5);
        check("simul_run",    running, 1);
        check("simul_no_clr", clr,     0);
        hold(0, 0, 6);

        // button held through reset release
        reset     = 1'b0;
        btn_start = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        hold(1, 0, 4);
        check("held_rst_wait", running, 0);
        step(1, 0);
        check("held_rst_accept", running, 1);
        hold(0, 0, 6);

        // random button activity against the model
        for (int seg = 0; seg < 2500; seg++) begin
            rs  = 1'($urandom_range(0, 1));
            rc  = ($urandom_range(0, 3) == 0);
            len = $urandom_range(1, 9);
            hold(rs, rc, len);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Front-end control stage for the stopwatch datapath. Takes two raw push-buttons (start/stop and clear), synchronises and debounces them, runs an IDLE/RUN/PAUSE state machine, and divides the system clock into a one-cycle `enable` pulse. That pulse drives the `enable` input of the downstream 4-bit time counter directly. The block also provides a run-status output and a one-cycle clear strobe for the display/readout logic.

## Interface
- `DIV`, default 1000: clock cycles per `enable` pulse; legal range ≥ 2.
- `DB_CYCLES`, default 16: consecutive stable synchronised samples required to accept a button level change; legal range ≥ 1.
- `clk` input 1: single system clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `btn_start` input 1: raw start/stop button, active-high, asynchronous to `clk`, may bounce.
- `btn_clear` input 1: raw clear button, active-high, asynchronous, may bounce.
- `enable` output 1: registered; high for exactly one cycle every `DIV` cycles while in RUN.
- `running` output 1: registered; high while state is RUN.
- `clr` output 1: registered; high for one cycle on the PAUSE→IDLE transition.

## Operation
- **Reset** (`reset`=0, immediate):
  - state = IDLE.
  - `enable`=0, `running`=0, `clr`=0.
  - Synchronisers, debounced levels, debounce counters and the prescaler counter all cleared to 0.
- **Synchroniser:** two flops per button. All later logic sees only the synchronised signal.
- **Debounce, per button:**
  - `db_cnt` counts consecutive cycles in which the synchronised sample differs from the debounced level.
  - Any cycle where they match clears `db_cnt` to 0.
  - When the sample has differed on `DB_CYCLES` consecutive edges, the debounced level flips and `db_cnt` clears.
  - A press event is the rising flip of the debounced level. It acts on the FSM at the same edge as the flip.
  - Release flips produce no event.
  - A button held through reset release is accepted as a press once debounce completes.
- **FSM** (next state on press events):
  - IDLE: start → RUN. Clear → stay IDLE, no `clr`.
  - RUN: start → PAUSE. Clear is ignored.
  - PAUSE: start → RUN. Clear → IDLE with `clr`=1 for one cycle.
  - Start and clear pressed on the same edge in PAUSE: start wins (→ RUN), clear is dropped.
- **Prescaler:** counter `div_cnt`, width ceil(log2(DIV)).
  - Set to 0 on any entry into IDLE and held at 0 in IDLE.
  - In RUN: increments each edge and wraps DIV-1 → 0. The wrap edge registers `enable`=1 for the following cycle.
  - In PAUSE: holds its value, so phase is preserved across pause/resume.
  - If RUN→PAUSE happens on the same edge as the wrap: `enable` stays 0 and `div_cnt` holds DIV-1.
- `running` is registered equal to (next state == RUN).

## Timing
- **Button latency:** raw high is first sampled at edge 1. Sync output is high after edge 2. The debounced flip, and the FSM transition, occur at edge `DB_CYCLES`+2.
- Bounce shorter than `DB_CYCLES` consecutive cycles produces no event.
- **First pulse:** the first `enable` is high in the cycle following edge `DIV` counted from the IDLE→RUN edge. After that, `enable` is high once every `DIV` cycles, never on two consecutive cycles.
- **Resume:** after PAUSE→RUN at residual count r, the next `enable` follows the edge `DIV`-r after the resume edge.
- `clr` and `running` change on the same edge as the state transition.
- Reset asserted mid-RUN clears all outputs immediately, without waiting for a clock edge.

## Test plan
Bench parameters for all scenarios: DIV=4, DB_CYCLES=3.
- **Reset check:** reset low then released, buttons low → `enable`=`running`=`clr`=0; no state change for 50 cycles.
- **Clean start:** clean `btn_start` pulse 10 cycles wide → state RUN at edge 5 after first sampling. `enable` pulses at cycles 4, 8, 12, … after entry; each pulse is exactly 1 cycle wide.
- **Bounce rejection:** `btn_start` toggling 1,0,1,1,0,1,1,1 → exactly one press, accepted at the third consecutive high plus 2 sync edges.
- **Pause phase hold:** start, then pause when `div_cnt`=2 → `enable` stays 0 during PAUSE. Resume → first `enable` 2 cycles after the resume edge.
- **Clear behaviour:** clear pressed in RUN → ignored. Pause, then clear → IDLE with one-cycle `clr`=1 and `div_cnt`=0. Next start → first `enable` 4 cycles after entry.
- **Simultaneous and reset cases:**
  - Start and clear debounced on the same edge in PAUSE → RUN, `clr` stays 0.
  - Reset asserted asynchronously between edges during RUN → outputs 0 immediately.
